// File: rtl/g2b_pkg.sv
// Shared definitions for the Gray-to-binary converter.
package g2b_pkg;

    localparam int G2B_WIDTH_DEFAULT = 4;

    // Prefix-XOR decode of the low 'width' bits of gray; upper bits return 0.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] gray, input int width);
        logic [31:0] bin;
        bin = '0;
        for (int i = 31; i >= 0; i--) begin
            if (i == width - 1) begin
                bin[i] = gray[i];
            end else if (i < width - 1) begin
                bin[i] = bin[i+1] ^ gray[i];
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/g2b_xor_chain.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all
// Gray bits at or above it.
module g2b_xor_chain
    import g2b_pkg::*;
#(
    parameter int WIDTH = G2B_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each bit is an independent reduction so no bit depends on another output bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/g2b.sv
// Gray-to-binary converter with a zero-latency result and a one-cycle
// registered copy qualified by out_valid.
module g2b
    import g2b_pkg::*;
#(
    parameter int WIDTH = G2B_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    output logic             parity
);

    logic [WIDTH-1:0] bin;

    g2b_xor_chain #(
        .WIDTH(WIDTH)
    ) u_xor_chain (
        .gray(in),
        .bin (bin)
    );

    assign out    = bin;
    // The LSB of the prefix-XOR is the XOR of every Gray bit.
    assign parity = bin[0];

    // Capture the decoded word on in_valid; valid pulses one cycle per capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= bin;
            end
        end
    end

endmodule

// File: tb/tb_g2b.sv
// Directed bench for g2b at WIDTH=4 and WIDTH=8.
module tb_g2b;
    import g2b_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] in4;
    logic       vld4;
    logic [3:0] out4;
    logic [3:0] outq4;
    logic       ovld4;
    logic       par4;
    logic [7:0] in8;
    logic       vld8;
    logic [7:0] out8;
    logic [7:0] outq8;
    logic       ovld8;
    logic       par8;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [3:0] EXP4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h7, 4'h6, 4'h4, 4'h5,
                                         4'hF, 4'hE, 4'hC, 4'hD, 4'h8, 4'h9, 4'hB, 4'hA};

    g2b #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in(in4), .in_valid(vld4),
        .out(out4), .out_q(outq4), .out_valid(ovld4), .parity(par4)
    );

    g2b #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in(in8), .in_valid(vld8),
        .out(out8), .out_q(outq8), .out_valid(ovld8), .parity(par8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent shift-XOR formulation of the decode.
    function automatic logic [31:0] ref_bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s++) b = b ^ (g >> s);
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] g8;
        logic [3:0] b2b [4];
        rst  = 1'b1;
        in4  = '0;
        vld4 = 1'b0;
        in8  = '0;
        vld8 = 1'b0;
        #2;
        chk("rst_out_q", 32'(outq4), 32'h0);
        chk("rst_out_valid", 32'(ovld4), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive 4-bit sweep on the combinational path.
        for (int i = 0; i < 16; i++) begin
            in4 = 4'(i);
            #1;
            chk($sformatf("sweep_out_%0h", i), 32'(out4), 32'(EXP4[i]));
            chk($sformatf("sweep_par_%0h", i), 32'(par4), 32'(EXP4[i][0]));
            #9;
        end

        // Spot values and boundaries.
        in4 = 4'b0010; #1; chk("spot_0010", 32'(out4), 32'b0011);
        in4 = 4'b0110; #1; chk("spot_0110", 32'(out4), 32'b0100);
        in4 = 4'b0101; #1; chk("spot_0101", 32'(out4), 32'b0110);
        in4 = 4'b1000; #1; chk("spot_1000", 32'(out4), 32'b1111);
        in4 = 4'b1111; #1; chk("spot_1111", 32'(out4), 32'b1010);
        chk("pkg_fn_1000", gray_to_bin(32'h8, 4), 32'hF);
        chk("pkg_fn_1111", gray_to_bin(32'hF, 4), 32'hA);
        chk("pkg_fn_80_w8", gray_to_bin(32'h80, 8), 32'hFF);

        // Registered capture then hold.
        @(negedge clk);
        in4 = 4'b1100; vld4 = 1'b1;
        @(posedge clk); #1;
        chk("reg_out_q", 32'(outq4), 32'b1000);
        chk("reg_out_valid", 32'(ovld4), 32'h1);
        @(negedge clk);
        in4 = 4'b0111; vld4 = 1'b0;
        @(posedge clk); #1;
        chk("hold_out_valid", 32'(ovld4), 32'h0);
        chk("hold_out_q", 32'(outq4), 32'b1000);

        // Back-to-back captures.
        b2b[0] = 4'b0000; b2b[1] = 4'b0001; b2b[2] = 4'b0011; b2b[3] = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in4 = b2b[i]; vld4 = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("b2b_out_q_%0d", i), 32'(outq4), 32'(i));
            chk($sformatf("b2b_out_valid_%0d", i), 32'(ovld4), 32'h1);
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        in4 = 4'b1111; vld4 = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_out_q", 32'(outq4), 32'b1010);
        chk("pre_rst_out_valid", 32'(ovld4), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_q", 32'(outq4), 32'h0);
        chk("async_rst_out_valid", 32'(ovld4), 32'h0);
        chk("rst_comb_out", 32'(out4), 32'b1010);
        in4 = 4'b0010; #1;
        chk("rst_comb_track", 32'(out4), 32'b0011);
        @(posedge clk); #1;
        chk("rst_held_out_q", 32'(outq4), 32'h0);
        chk("rst_held_out_valid", 32'(ovld4), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in4 = 4'b0110; vld4 = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_out_q", 32'(outq4), 32'b0100);
        chk("post_rst_out_valid", 32'(ovld4), 32'h1);
        @(negedge clk);
        vld4 = 1'b0;

        // WIDTH=8 boundaries and wrap.
        in8 = 8'h00; #1; chk("w8_zero", 32'(out8), 32'h00);
        in8 = 8'hFF; #1; chk("w8_ones", 32'(out8), 32'hAA);
        in8 = 8'h80; #1; chk("w8_wrap_max", 32'(out8), 32'hFF);
        chk("w8_wrap_par", 32'(par8), 32'h1);
        in8 = 8'h00; #1; chk("w8_wrap_zero", 32'(out8), 32'h00);
        in8 = 8'h5A; #1; chk("w8_spot_5a", 32'(out8), 32'h6C);

        // WIDTH=8 random sweep against the reference.
        for (int i = 0; i < 1000; i++) begin
            g8 = 8'($urandom_range(0, 255));
            in8 = g8;
            #1;
            chk($sformatf("w8_rand_%0h", g8), 32'(out8), ref_bin(32'(g8)));
            chk($sformatf("w8_rand_par_%0h", g8), 32'(par8), 32'(^g8));
        end

        // WIDTH=8 registered capture.
        @(negedge clk);
        in8 = 8'hC3; vld8 = 1'b1;
        @(posedge clk); #1;
        chk("w8_reg_out_q", 32'(outq8), 32'h82);
        chk("w8_reg_out_valid", 32'(ovld8), 32'h1);
        @(negedge clk);
        vld8 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/g2b.md
Name: g2b

Overview:
- Gray-code to natural-binary converter for WIDTH-bit codes (default 4), e.g. decoding Gray-coded counters/pointers crossing into a binary domain.
- Provides a zero-latency combinational result on out plus a one-cycle registered copy with a valid qualifier for pipelined consumers.
- Single clock domain; asynchronous active-high reset.

Parameters:
- WIDTH, 4, bit width of the Gray input and the binary outputs; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  asynchronous active-high reset; clears registered outputs.
- in  input  WIDTH  Gray-coded input word.
- in_valid  input  1  qualifies in for the registered path; ignored by the combinational path.
- out  output  WIDTH  combinational binary equivalent of in.
- out_q  output  WIDTH  registered binary result, captured on in_valid.
- out_valid  output  1  high for exactly one cycle after each cycle with in_valid=1.
- parity  output  1  combinational XOR of all bits of in; equals out[0].

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Conversion rule: out[WIDTH-1] = in[WIDTH-1]; out[i] = out[i+1] XOR in[i] for i = WIDTH-2 down to 0. Equivalently, out[i] is the XOR of in[WIDTH-1:i].
- out and parity are purely combinational from in. No clock dependency, no reset dependency. They settle within the same delta/cycle as the in change, with no latches.
- Registered path, on rising clk with rst low:
  - in_valid=1: out_q <= converted value of in; out_valid <= 1.
  - in_valid=0: out_q holds its previous value; out_valid <= 0.
- Latency: combinational path is 0 cycles; registered path is 1 cycle. Throughput is one word per cycle; back-to-back in_valid is fully supported with no stalls.
- Reset:
  - While rst=1: out_q=0 and out_valid=0, asserted immediately without waiting for clk.
  - Reset asserted mid-stream discards any capture in progress.
  - First capture occurs on the first rising clk after rst deasserts with in_valid=1.
- Boundaries:
  - All-zero Gray input gives all-zero binary.
  - All-ones Gray input gives an alternating pattern, MSB=1 (4-bit: 1111 -> 1010).
  - Gray 1000...0 gives all-ones binary.
  - Adjacent Gray codes give binary values differing by exactly 1, including the wrap from max code back to 0.
- X/Z on in propagates to the outputs. No sanitising is performed.

Decomposition:
- Shared package g2b_pkg: G2B_WIDTH_DEFAULT = 4; a function gray_to_bin(WIDTH) implementing the prefix-XOR, reusable by other blocks and by the bench's reference model.
- One sub-module is natural: g2b_xor_chain, a parameterised combinational prefix-XOR (Gray -> binary).
- g2b instantiates g2b_xor_chain and adds the valid/output register stage and the parity tap.

Test Plan:
- Exhaustive sweep of in = 0x0..0xF, 10 ns apart, in_valid=0. Required out: 0,1,3,2,7,6,4,5,F,E,C,D,8,9,B,A respectively; parity equals out[0] for every value.
- Spot values: in=0010 -> out=0011; 0110 -> 0100; 0101 -> 0110; 1000 -> 1111; 1111 -> 1010.
- Registered path: in_valid=1 with in=1100 at edge N gives out_q=1000 and out_valid=1 after edge N. With in_valid=0 at edge N+1, out_valid=0 and out_q stays 1000.
- Back-to-back: in_valid held high while in steps 0000, 0001, 0011, 0010 on consecutive edges gives out_q = 0, 1, 2, 3 on the following edges, with out_valid continuously 1.
- Asynchronous reset: assert rst between clock edges while out_valid=1 and out_q=1010. Both clear to 0 immediately. The combinational out still tracks in during reset.
- Re-parameterise WIDTH=8 and run a random sweep of 1000 values. out matches the gray_to_bin reference. Successive Gray codes 0x80 -> 0x00 give binary 0xFF -> 0x00 (wrap).
